frame_gen: RTL and testbench
============================

Name: frame_gen

Overview:
Transmit-side framer. Emits periodic frames of FRAME_LEN words: one SYNC_WORD slot flagged by sof, then FRAME_LEN-1 payload slots. Payload words come from an upstream valid/ready source; a fill word is inserted on underrun. Feeds the receive-side framer controller, which hunts for SYNC_WORD, and exports a Gray-coded frame counter for cross-domain monitoring.

Parameters:
DATA_W, 4, width of in_data/tx_data/sync/fill words
FRAME_LEN, 8, words per frame including sync slot (>=2)
SYNC_WORD, 4'b1101, word transmitted in sync slot
FILL_WORD, 4'b0000, word transmitted in payload slot when in_valid low
CNT_W, 4, frame counter width

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
enable  in  1  run request; sampled each cycle
in_data  in  DATA_W  payload word from upstream
in_valid  in  1  in_data valid
in_ready  out  1  combinational; upstream word accepted this cycle when in_valid&&in_ready
tx_data  out  DATA_W  registered transmitted word
tx_valid  out  1  registered; high in SYNC and PAYLOAD
sof  out  1  registered; high only in SYNC slot
state  out  2  current state: IDLE=00, SYNC=01, PAYLOAD=10
tx_fill  out  1  registered; high in payload slot carrying FILL_WORD
frame_cnt_gray  out  CNT_W  registered Gray code of frame count

Behaviour:
- Reset (async, any time incl. mid-frame): state=IDLE, slot_cnt=0, frame count=0, tx_data=0, tx_valid=0, sof=0, tx_fill=0, frame_cnt_gray=0; in_ready=0 while reset high. Partial frame abandoned, no completion.
- next_state (from state, slot_cnt, enable only; never from in_valid, so no comb loop):
  IDLE: enable ? SYNC : IDLE.
  SYNC: PAYLOAD, slot_cnt<=1.
  PAYLOAD: slot_cnt<FRAME_LEN-1 ? PAYLOAD (slot_cnt+1) : (enable ? SYNC : IDLE), slot_cnt<=0.
  2'b11 unreachable; decoded as IDLE.
- enable deassert mid-frame: current frame completes all FRAME_LEN-1 payload slots, then IDLE. Reassert during PAYLOAD last slot: goes straight to SYNC, back-to-back frames.
- in_ready = (next_state==PAYLOAD). Accepted word appears on tx_data next cycle (1-cycle latency); no word accepted while next slot is SYNC or IDLE.
- Output registers loaded on the edge entering next_state:
  SYNC: tx_data<=SYNC_WORD, sof<=1, tx_valid<=1, tx_fill<=0, frame count+1 (wraps 2^CNT_W-1 -> 0), frame_cnt_gray<=g(count+1).
  PAYLOAD: tx_valid<=1, sof<=0; in_valid ? (tx_data<=in_data, tx_fill<=0) : (tx_data<=FILL_WORD, tx_fill<=1).
  IDLE: tx_data<=0, tx_valid<=0, sof<=0, tx_fill<=0; frame count held.
- Gray: g = b ^ (b>>1). Consecutive frames differ in exactly one bit, incl. wrap.
- Frame period with enable held: exactly FRAME_LEN cycles between sof pulses.
- in_data equal to SYNC_WORD in payload is transmitted unmodified (no stuffing); receiver resolves by periodicity.

Decomposition:
- Package frame_pkg: state encodings ST_IDLE/ST_SYNC/ST_PAYLOAD, default SYNC_WORD/FILL_WORD constants, state width.
- One sub-module: gray_enc (parameterised width, combinational bin->Gray), instantiated on the frame counter next value.
- Top holds FSM, slot counter, output registers.

Test Plan:
- Reset, enable=1 at cycle 0 with in_valid=1 counting data 1,2,3..: cycle 1 state=01, sof=1, tx_data=1101, frame_cnt_gray=0001; cycles 2-8 tx_data=1..7, state=10; cycle 9 sof=1, gray=0011.
- in_valid=0 throughout, enable=1: payload slots tx_data=0000, tx_fill=1; in_ready high 7 of every 8 cycles, low the cycle before each SYNC.
- enable dropped at payload slot 3: slots 4-7 still sent, then state=00, tx_valid=0, in_ready=0; re-enable -> SYNC with gray incremented by one step.
- Run 16 frames: gray sequence 0001,0011,0010,...,1000,0000 (wrap), one bit change per frame; sof spacing always 8.
- Assert reset at payload slot 5: outputs zero asynchronously, state=00; release with enable=1 -> SYNC next edge, gray=0001.
- in_data=1101 in payload: transmitted as 1101 with sof=0, tx_fill=0.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared encodings and default words for the transmit-side framer.
package frame_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 2'b00,
        ST_SYNC    = 2'b01,
        ST_PAYLOAD = 2'b10
    } state_t;

    localparam logic [3:0] DEF_SYNC_WORD = 4'b1101;
    localparam logic [3:0] DEF_FILL_WORD = 4'b0000;

endpackage

// File: rtl/frame_gen_gray_enc.sv
// Combinational binary to Gray code converter.
module gray_enc #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] bin,
    output logic [W-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/frame_gen.sv
// Transmit framer: one sync slot then FRAME_LEN-1 payload slots per frame,
// fill word on underrun, Gray-coded frame counter for cross-domain monitors.
module frame_gen
    import frame_pkg::*;
#(
    parameter int unsigned DATA_W    = 4,
    parameter int unsigned FRAME_LEN = 8,
    parameter logic [DATA_W-1:0] SYNC_WORD = DATA_W'(DEF_SYNC_WORD),
    parameter logic [DATA_W-1:0] FILL_WORD = DATA_W'(DEF_FILL_WORD),
    parameter int unsigned CNT_W     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    output logic              sof,
    output logic [1:0]        state,
    output logic              tx_fill,
    output logic [CNT_W-1:0]  frame_cnt_gray
);

    localparam int unsigned SLOT_W = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_LEN - 1);

    state_t             state_q, next_state;
    logic [SLOT_W-1:0]  slot_q, next_slot;
    logic [CNT_W-1:0]   cnt_q, cnt_next, gray_next;

    assign cnt_next = cnt_q + CNT_W'(1);

    gray_enc #(.W(CNT_W)) u_gray (
        .bin  (cnt_next),
        .gray (gray_next)
    );

    // State and slot registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            slot_q  <= '0;
        end else begin
            state_q <= next_state;
            slot_q  <= next_slot;
        end
    end

    // Next state depends only on state, slot and enable, so in_ready has no path from in_valid
    always_comb begin
        next_state = ST_IDLE;
        next_slot  = '0;
        case (state_q)
            ST_SYNC: begin
                next_state = ST_PAYLOAD;
                next_slot  = SLOT_W'(1);
            end
            ST_PAYLOAD: begin
                if (slot_q < LAST_SLOT) begin
                    next_state = ST_PAYLOAD;
                    next_slot  = slot_q + SLOT_W'(1);
                end else if (enable) begin
                    next_state = ST_SYNC;
                end
            end
            default: begin
                if (enable) begin
                    next_state = ST_SYNC;
                end
            end
        endcase
    end

    assign in_ready = (next_state == ST_PAYLOAD) && !reset;
    assign state    = state_q;

    // Output registers load the word for the slot being entered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_data        <= '0;
            tx_valid       <= 1'b0;
            sof            <= 1'b0;
            tx_fill        <= 1'b0;
            cnt_q          <= '0;
            frame_cnt_gray <= '0;
        end else begin
            case (next_state)
                ST_SYNC: begin
                    tx_data        <= SYNC_WORD;
                    tx_valid       <= 1'b1;
                    sof            <= 1'b1;
                    tx_fill        <= 1'b0;
                    cnt_q          <= cnt_next;
                    frame_cnt_gray <= gray_next;
                end
                ST_PAYLOAD: begin
                    tx_valid <= 1'b1;
                    sof      <= 1'b0;
                    if (in_valid) begin
                        tx_data <= in_data;
                        tx_fill <= 1'b0;
                    end else begin
                        tx_data <= FILL_WORD;
                        tx_fill <= 1'b1;
                    end
                end
                default: begin
                    tx_data  <= '0;
                    tx_valid <= 1'b0;
                    sof      <= 1'b0;
                    tx_fill  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_gen.sv
// Self-checking bench for frame_gen: directed vector table, then scoreboarded sequences.
module tb_frame_gen;

    localparam int FL = 8;

    logic       clk, reset, enable, in_valid, in_ready;
    logic [3:0] in_data, tx_data, frame_cnt_gray;
    logic       tx_valid, sof, tx_fill;
    logic [1:0] state;

    frame_gen dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .sof            (sof),
        .state          (state),
        .tx_fill        (tx_fill),
        .frame_cnt_gray (frame_cnt_gray)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] st;
        logic [3:0] data;
        logic       valid;
        logic       sof;
        logic       fill;
        logic [3:0] gray;
    } exp_t;

    typedef struct packed {
        logic       en;
        logic       iv;
        logic [3:0] d;
        logic       rdy;
        exp_t       e;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[12];
    int   checks = 0;
    int   passes = 0;
    int   m_pos  = -1;   // -1 idle, 0 sync, 1..FL-1 payload slot
    int   m_cnt  = 0;
    int   cyc    = 0;
    int   last_sof = -1;
    logic [3:0] last_gray = '0;

    function automatic logic [3:0] to_gray(input int b);
        logic [4:0] v;
        logic [3:0] g;
        v = 5'(b);
        for (int i = 0; i < 4; i++) g[i] = v[i] ^ v[i+1];
        return g;
    endfunction

    function automatic vec_t mkv(input logic en, input logic iv, input logic [3:0] d,
                                 input logic rdy, input logic [1:0] st, input logic [3:0] data,
                                 input logic valid, input logic s, input logic fill,
                                 input logic [3:0] gray);
        vec_t v;
        v.en = en; v.iv = iv; v.d = d; v.rdy = rdy;
        v.e.st = st; v.e.data = data; v.e.valid = valid;
        v.e.sof = s; v.e.fill = fill; v.e.gray = gray;
        return v;
    endfunction

    function automatic exp_t actual();
        exp_t a;
        a.st = state; a.data = tx_data; a.valid = tx_valid;
        a.sof = sof; a.fill = tx_fill; a.gray = frame_cnt_gray;
        return a;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s @%0t cyc %0d: got %h expected %h", name, $time, cyc, act, exp);
        else
            passes++;
    endtask

    // Advances the reference model one cycle; returns expected in_ready and outputs
    task automatic model_step(input logic en, input logic iv, input logic [3:0] d,
                              output logic rdy, output exp_t e);
        int np;
        if (m_pos < 0)            np = en ? 0 : -1;
        else if (m_pos < FL - 1)  np = m_pos + 1;
        else                      np = en ? 0 : -1;
        rdy = (np > 0);
        if (np == 0) begin
            m_cnt = (m_cnt + 1) % 16;
            e = {2'b01, 4'b1101, 1'b1, 1'b1, 1'b0, to_gray(m_cnt)};
        end else if (np > 0) begin
            e = {2'b10, (iv ? d : 4'b0000), 1'b1, 1'b0, !iv, to_gray(m_cnt)};
        end else begin
            e = {2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, to_gray(m_cnt)};
        end
        m_pos = np;
    endtask

    // Frame-level properties checked independently of the per-cycle model
    task automatic observe();
        if (state == 2'b00) last_sof = -1;
        if (sof) begin
            if (last_sof >= 0) chk("sof_spacing", 16'(cyc - last_sof), 16'(FL));
            chk("gray_one_bit", 16'($countones(frame_cnt_gray ^ last_gray)), 16'd1);
            last_sof  = cyc;
            last_gray = frame_cnt_gray;
        end
    endtask

    task automatic drive_cycle(input string name, input logic en, input logic iv,
                               input logic [3:0] d);
        logic rdy;
        exp_t e, got;
        enable = en; in_valid = iv; in_data = d;
        model_step(en, iv, d, rdy, e);
        sb_q.push_back(e);
        #1;
        chk({name, "_in_ready"}, 16'(in_ready), 16'(rdy));
        @(posedge clk); #1;
        cyc++;
        if (sb_q.size() == 0) begin
            chk({name, "_sb_empty"}, 16'd1, 16'd0);
        end else begin
            got = actual();
            chk(name, 16'(got), 16'(sb_q.pop_front()));
        end
        observe();
    endtask

    task automatic model_reset();
        m_pos = -1; m_cnt = 0; last_sof = -1; last_gray = '0;
        sb_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic rdy;
        exp_t e;

        // Directed frame from reset with counting upstream data
        vecs[0] = mkv(1, 1, 4'd1, 0, 2'b01, 4'hD, 1, 1, 0, 4'h1);
        for (int i = 1; i <= 7; i++)
            vecs[i] = mkv(1, 1, 4'(i), 1, 2'b10, 4'(i), 1, 0, 0, 4'h1);
        vecs[8]  = mkv(1, 1, 4'd8, 0, 2'b01, 4'hD, 1, 1, 0, 4'h3);
        vecs[9]  = mkv(1, 1, 4'd8, 1, 2'b10, 4'd8, 1, 0, 0, 4'h3);
        vecs[10] = mkv(1, 1, 4'hD, 1, 2'b10, 4'hD, 1, 0, 0, 4'h3);
        vecs[11] = mkv(1, 0, 4'h5, 1, 2'b10, 4'h0, 1, 0, 1, 4'h3);

        reset = 1'b1; enable = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 16'(actual()), 16'd0);
        chk("reset_in_ready", 16'(in_ready), 16'd0);
        reset = 1'b0;
        #1;
        chk("idle_in_ready", 16'(in_ready), 16'd0);

        foreach (vecs[i]) begin
            enable = vecs[i].en; in_valid = vecs[i].iv; in_data = vecs[i].d;
            model_step(vecs[i].en, vecs[i].iv, vecs[i].d, rdy, e);
            #1;
            chk($sformatf("vec%0d_in_ready", i), 16'(in_ready), 16'(vecs[i].rdy));
            @(posedge clk); #1;
            cyc++;
            chk($sformatf("vec%0d_out", i), 16'(actual()), 16'(vecs[i].e));
            observe();
        end

        // Underrun: every payload slot carries the fill word
        for (int i = 0; i < 16; i++) drive_cycle("fill", 1, 0, 4'h7);

        // Drop enable once payload slot 3 is on the wire
        n = 0;
        while (m_pos != 3 && n < 20) begin
            drive_cycle("pre_drop", 1, 1, 4'($urandom_range(0, 15)));
            n++;
        end
        if (m_pos != 3) chk("reach_slot3", 16'(m_pos), 16'd3);
        n = 0;
        while (m_pos != -1 && n < 20) begin
            drive_cycle("drain", 0, 1, 4'($urandom_range(0, 15)));
            n++;
        end
        chk("drain_slots", 16'(n), 16'(FL - 3));
        for (int i = 0; i < 3; i++) drive_cycle("idle", 0, 1, 4'h9);
        drive_cycle("reenable", 1, 1, 4'h2);

        // Sixteen back-to-back frames to cover counter wrap
        for (int i = 0; i < 16 * FL; i++)
            drive_cycle("run16", 1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));

        // Asynchronous reset in the middle of a frame
        n = 0;
        while (m_pos != 5 && n < 20) begin
            drive_cycle("pre_reset", 1, 1, 4'($urandom_range(0, 15)));
            n++;
        end
        if (m_pos != 5) chk("reach_slot5", 16'(m_pos), 16'd5);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_outputs", 16'(actual()), 16'd0);
        chk("async_reset_in_ready", 16'(in_ready), 16'd0);
        @(posedge clk); #1;
        model_reset();
        reset = 1'b0;
        drive_cycle("post_reset_sync", 1, 1, 4'h4);
        chk("post_reset_gray", 16'(frame_cnt_gray), 16'h1);
        for (int i = 0; i < 2 * FL; i++)
            drive_cycle("post_reset", 1, 1, 4'($urandom_range(0, 15)));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
